// File: rtl/div_sched_pkg.sv
// Shared constants, FSM state encodings and helpers for the div_sched scheduler.
// Optional statistics counters are built only when DIV_SCHED_STATS_EN is defined.
package div_sched_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int X_W   = 9;
    localparam int QUO_W = 4;
    localparam int REM_W = 5;
    localparam int STEPS = 4;
    localparam int CNT_W = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_TEST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Saturating increment used by the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/div_sched_if.sv
// Client-side bundle of the shared-divider scheduler (requests, operands, results).
interface div_sched_if
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4
);
    // req[i] is a level held (with stable operands) until the cycle done[i] pulses;
    // gnt is one-hot while a job runs; quo/rem/ovf are valid only while done != 0.
    logic [NREQ-1:0]       req;
    logic [NREQ*DVD_W-1:0] dividend_in;
    logic [NREQ*DVS_W-1:0] divisor_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [QUO_W-1:0]      quo;
    logic [REM_W-1:0]      rem;
    logic                  ovf;
    logic                  busy;

    modport master (
        output req, dividend_in, divisor_in,
        input  gnt, done, quo, rem, ovf, busy
    );

    modport slave (
        input  req, dividend_in, divisor_in,
        output gnt, done, quo, rem, ovf, busy
    );
endinterface

// File: rtl/div_sched_rr_arb.sv
// Combinational round-robin picker: search starts one past ptr and wraps.
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win_oh,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);

    int          cand;
    logic [IW-1:0] cidx;
    logic        found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        cidx    = '0;
        any     = |req;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            cidx = cand[IW-1:0];
            if (!found && req[cidx]) begin
                found        = 1'b1;
                win_oh[cidx] = 1'b1;
                win_idx      = cidx;
            end
        end
    end
endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sequencing one shared shift-subtract divider datapath.
// Define DIV_SCHED_STATS_EN to add the jobs_cnt/ovf_cnt saturating counters.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    div_sched_if.slave       bus,
    output logic [DVD_W-1:0] dp_dividend,
    output logic [DVS_W-1:0] dp_divisor,
    output logic             dp_ld,
    output logic             dp_sh,
    output logic             dp_su,
    input  logic             dp_c,
    input  logic [X_W-1:0]   dp_x,
`ifdef DIV_SCHED_STATS_EN
    output logic [CNT_W-1:0] jobs_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
`endif
    output state_t           dbg_state
);
    localparam int IW = $clog2(NREQ);
    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [1:0]      step;
    logic            ovf_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            any;
    logic            is_done;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            owner <= '0;
            ptr   <= IW'(NREQ - 1);
            step  <= '0;
            ovf_q <= 1'b0;
            gnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (any) begin
                    owner <= win_idx;
                    gnt_q <= win_oh;
                    ovf_q <= 1'b0;
                    state <= S_LOAD;
                end
                S_LOAD: state <= S_CHECK;
                // A quotient that cannot fit in QUO_W bits is detected before any shift.
                S_CHECK: if (dp_c) begin
                    ovf_q <= 1'b1;
                    state <= S_DONE;
                end else begin
                    step  <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: state <= S_TEST;
                S_TEST: if (step == LAST_STEP) begin
                    state <= S_DONE;
                end else begin
                    step  <= step + 2'd1;
                    state <= S_SHIFT;
                end
                S_DONE: begin
                    ptr   <= owner;
                    gnt_q <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign is_done   = (state == S_DONE);
    assign bus.busy  = (state != S_IDLE);
    assign bus.gnt   = gnt_q;
    assign bus.done  = is_done ? gnt_q : '0;
    assign bus.quo   = is_done ? dp_x[QUO_W-1:0] : '0;
    assign bus.rem   = is_done ? dp_x[X_W-1:QUO_W] : '0;
    assign bus.ovf   = is_done & ovf_q;
    assign dp_ld     = (state == S_LOAD);
    assign dp_sh     = (state == S_SHIFT);
    assign dp_su     = (state == S_TEST) & dp_c;
    assign dbg_state = state;

    // Owner operand mux; idle drives zeros so every output is 0 out of reset.
    always_comb begin
        dp_dividend = '0;
        dp_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.busy && owner == IW'(i)) begin
                dp_dividend = bus.dividend_in[i*DVD_W +: DVD_W];
                dp_divisor  = bus.divisor_in[i*DVS_W +: DVS_W];
            end
        end
    end

`ifdef DIV_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jobs_cnt <= '0;
            ovf_cnt  <= '0;
        end else if (is_done) begin
            jobs_cnt <= sat_inc(jobs_cnt);
            if (ovf_q) ovf_cnt <= sat_inc(ovf_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural shift-subtract datapath model.
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int NREQ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_sched_if #(.NREQ(NREQ)) bus ();

  logic [DVD_W-1:0] dp_dividend;
  logic [DVS_W-1:0] dp_divisor;
  logic             dp_ld, dp_sh, dp_su, dp_c;
  logic [X_W-1:0]   dp_x;
  state_t           dbg_state;
`ifdef DIV_SCHED_STATS_EN
  logic [15:0]      jobs_cnt, ovf_cnt;
`endif

  div_sched #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dp_dividend (dp_dividend),
    .dp_divisor  (dp_divisor),
    .dp_ld       (dp_ld),
    .dp_sh       (dp_sh),
    .dp_su       (dp_su),
    .dp_c        (dp_c),
    .dp_x        (dp_x),
`ifdef DIV_SCHED_STATS_EN
    .jobs_cnt    (jobs_cnt),
    .ovf_cnt     (ovf_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // Reference datapath: 9-bit register, upper 5 bits partial remainder, lower 4 quotient.
  always @(posedge clk or posedge rst) begin
    if (rst) dp_x <= '0;
    else if (dp_ld) dp_x <= {1'b0, dp_dividend};
    else if (dp_sh) dp_x <= dp_x << 1;
    else if (dp_su) dp_x <= {dp_x[8:4] - {1'b0, dp_divisor}, dp_x[3:1], 1'b1};
  end
  assign dp_c = (dp_x[8:4] >= {1'b0, dp_divisor});

  // Control pulse monitor.
  int ld_tot = 0, sh_tot = 0, su_tot = 0, excl_err = 0;
  always @(negedge clk) begin
    if (int'(dp_ld) + int'(dp_sh) + int'(dp_su) > 1) excl_err++;
    ld_tot += int'(dp_ld);
    sh_tot += int'(dp_sh);
    su_tot += int'(dp_su);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [NREQ-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic [7:0] dvd, input logic [3:0] dvs);
    bus.dividend_in[idx*8 +: 8] = dvd;
    bus.divisor_in[idx*4 +: 4]  = dvs;
  endtask

  // Waits (bounded) for a done pulse; n = rising edges consumed.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.done == '0 && n < 100);
    check("done_seen", 32'(bus.done != '0), 32'd1);
  endtask

  task automatic run_job(input int idx, input logic [7:0] dvd, input logic [3:0] dvs,
                         input logic [3:0] eq, input logic [4:0] er, input logic eo,
                         input int elat);
    int n, ld0, sh0, su0;
    string tag;
    tag = $sformatf("job%0d_%0d_%0d", idx, dvd, dvs);
    set_ops(idx, dvd, dvs);
    bus.req[idx] = 1'b1;
    ld0 = ld_tot; sh0 = sh_tot; su0 = su_tot;
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'(elat));
    check({tag, "_done"}, 32'(bus.done), 32'(1 << idx));
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << idx));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, "_quo"}, 32'(bus.quo), 32'(eq));
    check({tag, "_rem"}, 32'(bus.rem), 32'(er));
    bus.req[idx] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_gnt"}, 32'(bus.gnt), 32'd0);
    check({tag, "_ld_pulses"}, 32'(ld_tot - ld0), 32'd1);
    check({tag, "_sh_pulses"}, 32'(sh_tot - sh0), eo ? 32'd0 : 32'd4);
    check({tag, "_su_pulses"}, 32'(su_tot - su0), eo ? 32'd0 : 32'($countones(eq)));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         idx;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [4:0] r;
    logic       o;
    int         lat;
  } vec_t;

  vec_t vecs[9];
  logic [3:0] sat_q[4];
  logic [4:0] sat_r[4];

  initial begin
    int n;
    vecs[0] = '{0, 8'd135, 4'd13, 4'd10, 5'd5,  1'b0, 11};
    vecs[1] = '{1, 8'd100, 4'd7,  4'd14, 5'd2,  1'b0, 11};
    vecs[2] = '{2, 8'd200, 4'd15, 4'd13, 5'd5,  1'b0, 11};
    vecs[3] = '{3, 8'd0,   4'd5,  4'd0,  5'd0,  1'b0, 11};
    vecs[4] = '{0, 8'hF0,  4'd3,  4'h0,  5'h0F, 1'b1, 3};
    vecs[5] = '{1, 8'd50,  4'd0,  4'd2,  5'd3,  1'b1, 3};
    vecs[6] = '{2, 8'd255, 4'd15, 4'd15, 5'd15, 1'b1, 3};
    vecs[7] = '{3, 8'd239, 4'd15, 4'd15, 5'd14, 1'b0, 11};
    vecs[8] = '{0, 8'd13,  4'd1,  4'd13, 5'd0,  1'b0, 11};
    sat_q = '{4'd10, 4'd14, 4'd13, 4'd13};
    sat_r = '{5'd5,  5'd2,  5'd5,  5'd0};

    bus.req = '0;
    bus.dividend_in = '0;
    bus.divisor_in = '0;

    // Reset state
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quo_rem_ovf", {23'd0, bus.quo, bus.rem}, 32'(bus.ovf));
    check("rst_dp_ctrl", {29'd0, dp_ld, dp_sh, dp_su}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    do_reset();

    // Table-driven single jobs
    for (int i = 0; i < 9; i++)
      run_job(vecs[i].idx, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].lat);
    check("mutex_ld_sh_su", 32'(excl_err), 32'd0);

    // Saturation: all four requesters held high
    do_reset();
    set_ops(0, 8'd135, 4'd13);
    set_ops(1, 8'd100, 4'd7);
    set_ops(2, 8'd200, 4'd15);
    set_ops(3, 8'd13,  4'd1);
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      logic [NREQ-1:0] e;
      e = exp_q.pop_front();
      wait_done(n);
      check($sformatf("sat%0d_period", k), 32'(n), (k == 0) ? 32'd11 : 32'd12);
      check($sformatf("sat%0d_done", k), 32'(bus.done), 32'(e));
      check($sformatf("sat%0d_gnt_eq_done", k), 32'(bus.gnt), 32'(e));
      check($sformatf("sat%0d_quo", k), 32'(bus.quo), 32'(sat_q[k % 4]));
      check($sformatf("sat%0d_rem", k), 32'(bus.rem), 32'(sat_r[k % 4]));
    end
    bus.req = '0;
    repeat (14) @(posedge clk);
    #1;

    // Reset mid-job while requester 2 is shifting
    do_reset();
    set_ops(2, 8'd200, 4'd15);
    bus.req[2] = 1'b1;
    n = 0;
    while (dbg_state != S_SHIFT && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_shift", 32'(dbg_state), 32'(S_SHIFT));
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_dp_sh", 32'(dp_sh), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    set_ops(0, 8'd135, 4'd13);
    bus.req[0] = 1'b1;
    rst = 1'b0;
    wait_done(n);
    check("abort_first_lat", 32'(n), 32'd11);
    check("abort_first_owner", 32'(bus.done), 32'b0001);
    check("abort_first_quo", 32'(bus.quo), 32'd10);
    bus.req[0] = 1'b0;
    wait_done(n);
    check("abort_reserve_lat", 32'(n), 32'd12);
    check("abort_reserve_owner", 32'(bus.done), 32'b0100);
    check("abort_reserve_quo", 32'(bus.quo), 32'd13);
    check("abort_reserve_rem", 32'(bus.rem), 32'd5);
    bus.req[2] = 1'b0;
    @(posedge clk); #1;

    // req[3] alone, req[1] raised mid-job
    set_ops(3, 8'd13, 4'd1);
    set_ops(1, 8'd100, 4'd7);
    exp_q = '{4'b1000, 4'b0010};
    bus.req[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.req[1] = 1'b1;
    wait_done(n);
    check("late_first_done", 32'(bus.done), 32'(exp_q.pop_front()));
    check("late_first_quo", 32'(bus.quo), 32'd13);
    bus.req[3] = 1'b0;
    wait_done(n);
    check("late_second_lat", 32'(n), 32'd12);
    check("late_second_done", 32'(bus.done), 32'(exp_q.pop_front()));
    check("late_second_quo", 32'(bus.quo), 32'd14);
    check("late_second_rem", 32'(bus.rem), 32'd2);
    bus.req[1] = 1'b0;
    @(posedge clk); #1;

`ifdef DIV_SCHED_STATS_EN
    do_reset();
    check("stats_rst_jobs", 32'(jobs_cnt), 32'd0);
    check("stats_rst_ovf", 32'(ovf_cnt), 32'd0);
    run_job(0, 8'd135, 4'd13, 4'd10, 5'd5, 1'b0, 11);
    run_job(1, 8'hF0,  4'd3,  4'h0,  5'h0F, 1'b1, 3);
    run_job(2, 8'd200, 4'd15, 4'd13, 5'd5, 1'b0, 11);
    run_job(3, 8'd50,  4'd0,  4'd2,  5'd3, 1'b1, 3);
    run_job(0, 8'd13,  4'd1,  4'd13, 5'd0, 1'b0, 11);
    check("stats_jobs", 32'(jobs_cnt), 32'd5);
    check("stats_ovf", 32'(ovf_cnt), 32'd2);
`endif

    check("mutex_final", 32'(excl_err), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sched.md
# div_sched

Shared-divider scheduler: arbitrates up to NREQ requesters round-robin onto one shift-subtract divider datapath and sequences it. It drives the datapath's load, shift and subtract controls from its compare output, and returns quotient, remainder and overflow to the winning requester. It sits between the client blocks and the single divider datapath, replacing per-client controllers.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level; held until that requester's done
- dividend_in  in  NREQ*8  per-requester dividend; slice i = bits [8i+7:8i]; stable while req[i]=1
- divisor_in  in  NREQ*4  per-requester divisor; slice i = bits [4i+3:4i]; stable while req[i]=1
- gnt  out  NREQ  one-hot current owner; 0 when idle
- done  out  NREQ  one-hot, one-cycle completion pulse
- quo  out  4  quotient, valid only while done≠0
- rem  out  5  remainder, valid only while done≠0
- ovf  out  1  overflow flag, valid only while done≠0
- busy  out  1  job in progress
- dp_dividend  out  8  operand to datapath = dividend_in slice of owner
- dp_divisor  out  4  operand to datapath = divisor_in slice of owner
- dp_ld  out  1  load dividend/divisor into datapath register
- dp_sh  out  1  shift datapath register left one bit
- dp_su  out  1  subtract divisor from upper bits, set quotient LSB
- dp_c  in  1  datapath compare: upper 5 bits ≥ divisor
- dp_x  in  9  datapath register; [8:4] remainder, [3:0] quotient
- jobs_cnt  out  16  completed jobs (only with DIV_SCHED_STATS_EN)
- ovf_cnt  out  16  overflowed jobs (only with DIV_SCHED_STATS_EN)

## Operation
- States: IDLE, LOAD, CHECK, SHIFT, TEST, DONE.
- IDLE: if any req, rr_arb picks the winner. Latch owner index, set gnt, go to LOAD. Otherwise stay.
- LOAD: dp_ld=1 for one cycle, then CHECK.
- CHECK: dp_c=1 → overflow latched, go to DONE. Else step counter=0, go to SHIFT.
- SHIFT: dp_sh=1, then TEST.
- TEST: dp_su=dp_c. If step=3 → DONE; else step+1 → SHIFT.
- DONE: done[owner]=1, quo=dp_x[3:0], rem=dp_x[8:4], ovf=latched flag. Pointer updates to owner. Next state IDLE; gnt clears.
- On overflow: quo/rem are the unmodified loaded value; the requester ignores them.
- Round-robin: search starts at last owner+1, wrapping NREQ-1→0. Reset pointer = NREQ-1, so req[0] wins first.
- Requester clears req on the edge where it samples done. A req still high in IDLE after its own done is treated as a new job.
- dp_ld/dp_sh/dp_su are mutually exclusive and 0 outside their states.
- busy=1 in every state except IDLE.
- Reset (asynchronous, any state): state=IDLE, all outputs 0, step=0, pointer=NREQ-1, stats 0. The aborted job produces no done; its requester, still holding req, is re-served.

## Timing
- req sampled in IDLE at edge T: LOAD T+1, CHECK T+2, SHIFT/TEST T+3..T+10, DONE T+11. Normal latency 11 cycles.
- Overflow: DONE at T+3, latency 3 cycles.
- Back-to-back: DONE → IDLE → next grant. 12-cycle job period under saturation, 4-cycle with overflow.
- Outputs gnt/dp_*/done are functions of registered state; quo/rem pass dp_x through combinationally during DONE.

## Configuration
- DIV_SCHED_STATS_EN defined: jobs_cnt and ovf_cnt ports exist. Both are 16-bit saturating counters, incremented in DONE (ovf_cnt only when ovf=1), cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- div_pkg: state enum, constants DVD_W=8, DVS_W=4, X_W=9, STEPS=4.
- Sub-module rr_arb: combinational one-hot round-robin picker (req, pointer → one-hot winner and index). Instantiated once in div_sched.

## Test plan
- Single job, req[0], dividend 135, divisor 13, dp_c from reference datapath model → done[0] at T+11, quo=10, rem=5, ovf=0.
- Overflow: dividend 0xF0, divisor 0x3 → DONE at T+3, ovf=1, dp_sh/dp_su never asserted.
- All four req high continuously → grants 0,1,2,3,0 in order; each done one-hot matches gnt; period 12 cycles.
- rst asserted mid-job in SHIFT of requester 2 → all outputs 0 immediately, no done[2]; after release, requester 0 (pointer reset) wins if requesting, else 2 is re-served with correct result.
- Only req[3] high, then req[1] raised during job → after done[3], req[1] granted next.
- With DIV_SCHED_STATS_EN: 3 normal jobs + 2 overflow jobs → jobs_cnt=5, ovf_cnt=2.
